conv_window_mac: RTL and testbench

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

---
 rtl/conv_window_mac.sv | 139 +++++++++++++
 tb/tb_conv_window_mac.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// conv_window_mac: KSIZE x KSIZE sliding-window multiply-accumulate over a raster pixel stream.
// The window shifts on each accepted pixel; results pass through a product stage and a sum+bias stage.
module conv_window_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int KSIZE      = 5,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                                  cw_clk,
  input  logic                                  cw_rst_b,
  input  logic                                  cw_en,
  input  logic                                  cw_frame_start_i,
  input  logic [KSIZE-1:0][DATA_WIDTH-1:0]       cw_rows_i,
  input  logic [KSIZE*KSIZE-1:0][DATA_WIDTH-1:0] cw_weights_i,
  input  logic [ACC_WIDTH-1:0]                  cw_bias_i,
  output logic [ACC_WIDTH-1:0]                  cw_data_o,
  output logic                                  cw_valid_o,
  output logic                                  cw_frame_done_o
);

  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int NTAPS  = KSIZE * KSIZE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d, cur_row;
  logic [COL_W-1:0]             col_q, col_d, cur_col;
  logic                         accept, launch, last_pix;
  logic signed [DATA_WIDTH-1:0] win_q [KSIZE][KSIZE];
  logic signed [PROD_W-1:0]     prod_q [NTAPS];
  logic                         launch_q, last_q, valid1_q, done1_q;
  logic signed [ACC_WIDTH-1:0]  sum;

  // row_q/col_q hold the position the next accepted pixel will occupy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cur_row  = row_q;
    cur_col  = col_q;
    accept   = 1'b0;
    launch   = 1'b0;
    last_pix = 1'b0;

    if (cw_en && cw_frame_start_i) begin
      accept  = 1'b1;
      cur_row = '0;
      cur_col = '0;
      state_d = RUN;
    end else if (cw_en && state_q == RUN) begin
      accept = 1'b1;
    end

    if (accept) begin
      launch   = (cur_row >= ROW_W'(KSIZE - 1)) && (cur_col >= COL_W'(KSIZE - 1));
      last_pix = (cur_row == ROW_W'(IMG_HEIGHT - 1)) && (cur_col == COL_W'(IMG_WIDTH - 1));
      if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
      if (last_pix) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    end
  end

  always_comb begin
    // NOTE: blocking assignments here build the adder chain in order; state elements use <= only.
    sum = $signed(cw_bias_i);
    for (int i = 0; i < NTAPS; i++) begin
      sum = sum + ACC_WIDTH'(prod_q[i]);
    end
  end

  always_ff @(posedge cw_clk) begin
    if (!cw_rst_b) begin
      state_q         <= IDLE;
      row_q           <= '0;
      col_q           <= '0;
      launch_q        <= 1'b0;
      last_q          <= 1'b0;
      valid1_q        <= 1'b0;
      done1_q         <= 1'b0;
      cw_valid_o      <= 1'b0;
      cw_frame_done_o <= 1'b0;
      cw_data_o       <= '0;
      // NOTE: window and product arrays are flip-flops, not RAM, so clearing them on reset is legal and required.
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
      for (int i = 0; i < NTAPS; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      launch_q <= launch;
      last_q   <= launch && last_pix;

      // Top window row takes the oldest line-buffer tap.
      if (accept) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][KSIZE-1] <= $signed(cw_rows_i[KSIZE-1-r]);
        end
      end

      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          prod_q[r*KSIZE+c] <= PROD_W'(win_q[r][c]) * PROD_W'($signed(cw_weights_i[r*KSIZE+c]));
        end
      end
      valid1_q <= launch_q;
      done1_q  <= last_q;

      cw_valid_o      <= valid1_q;
      cw_frame_done_o <= done1_q;
      if (valid1_q) begin
        cw_data_o <= sum;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: frame-level directed tests of conv_window_mac; expected results come from a
// convolution model and wait in a scoreboard queue together with their frame_done flag and arrival cycle.
`timescale 1ns/1ps
module tb_conv_window_mac;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 40;
  localparam int NT = K * K;

  typedef struct {
    logic signed [AW-1:0] data;
    logic                 done;
    int                   cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_b = 1'b0;
  logic                 en = 1'b0;
  logic                 fs = 1'b0;
  logic [K-1:0][DW-1:0]  rows = '0;
  logic [NT-1:0][DW-1:0] weights = '0;
  logic [AW-1:0]        bias = '0;
  logic [AW-1:0]        data;
  logic                 valid;
  logic                 done;

  exp_t                 sb[$];
  int                   cyc = 0;
  bit                   rst_at_edge = 1'b1;
  int                   n_assert = 0;
  int                   n_fail = 0;
  int                   results_seen = 0;
  int                   done_seen = 0;
  logic signed [AW-1:0] hold_exp = '0;
  logic signed [AW-1:0] first_data = '0;
  int                   pix_mode = 0;  // 0: all ones, 1: ramp row*W+col, 2: all minus one

  conv_window_mac #(
    .DATA_WIDTH(DW), .KSIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ACC_WIDTH(AW)
  ) dut (
    .cw_clk          (clk),
    .cw_rst_b        (rst_b),
    .cw_en           (en),
    .cw_frame_start_i(fs),
    .cw_rows_i       (rows),
    .cw_weights_i    (weights),
    .cw_bias_i       (bias),
    .cw_data_o       (data),
    .cw_valid_o      (valid),
    .cw_frame_done_o (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = !rst_b;
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] pix(input int r, input int c);
    if (r < 0 || c < 0) return '0;
    case (pix_mode)
      0:       return DW'(1);
      1:       return DW'(r * W + c);
      default: return -DW'(1);
    endcase
  endfunction

  function automatic logic signed [AW-1:0] model(input int r, input int c);
    longint acc = longint'($signed(bias));
    for (int rr = 0; rr < K; rr++) begin
      for (int cc = 0; cc < K; cc++) begin
        acc += longint'(pix(r - (K - 1) + rr, c - (K - 1) + cc)) * longint'($signed(weights[rr*K+cc]));
      end
    end
    return AW'(acc);
  endfunction

  // Output monitor: reset values, scoreboard compare with latency, hold while idle.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_valid", valid, 0);
      check("reset_done", done, 0);
      check("reset_data", $signed(data), 0);
      hold_exp = '0;
    end else if (valid) begin
      check("sb_pending", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data", $signed(data), e.data);
        check("frame_done", done, e.done);
        check("latency_cycle", cyc, e.cyc);
        if (results_seen == 0) first_data = $signed(data);
        results_seen++;
        if (done) done_seen++;
        hold_exp = e.data;
      end
    end else begin
      check("hold_data", $signed(data), hold_exp);
      check("done_without_valid", done, 0);
    end
  end

  task automatic drive(input int r, input int c, input bit start, input bit rst_now);
    @(negedge clk);
    en    = 1'b1;
    fs    = start;
    rst_b = !rst_now;
    for (int k = 0; k < K; k++) rows[k] = pix(r - k, c);
    if (rst_now) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    end else if (r >= K - 1 && c >= K - 1) begin
      sb.push_back('{data: model(r, c), done: (r == H - 1 && c == W - 1), cyc: cyc + 3});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en    = 1'b0;
      fs    = 1'b0;
      rst_b = 1'b1;
    end
  endtask

  // Drives a frame from (0,0) up to, but not including, (stop_r, stop_c).
  task automatic run_frame(input bit gaps, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        drive(r, c, (r == 0 && c == 0), 1'b0);
      end
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_frame(input string tag, input int exp_res, input int exp_done);
    check({tag, "_results"}, results_seen, exp_res);
    check({tag, "_frame_done_count"}, done_seen, exp_done);
    results_seen = 0;
    done_seen    = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    // All ones, unit weights, zero bias; stray cw_en in IDLE must do nothing.
    pix_mode = 0;
    for (int i = 0; i < NT; i++) weights[i] = DW'(1);
    bias = '0;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b1;
      fs = 1'b0;
      for (int k = 0; k < K; k++) rows[k] = DW'($urandom);
    end
    idle(4);
    check_frame("idle_ignore", 0, 0);
    run_frame(1'b0, -1, -1);
    drain();
    check("ones_first", first_data, 25);
    check_frame("ones", 784, 1);

    // Ramp with centre-tap weight only.
    pix_mode = 1;
    for (int i = 0; i < NT; i++) weights[i] = '0;
    weights[12] = DW'(1);
    run_frame(1'b0, -1, -1);
    drain();
    check("ramp_first", first_data, 66);
    check_frame("ramp", 784, 1);

    // Same ramp with random enable gaps.
    run_frame(1'b1, -1, -1);
    drain();
    check("gaps_first", first_data, 66);
    check_frame("gaps", 784, 1);

    // Negative pixels, max positive weights, negative bias.
    pix_mode = 2;
    for (int i = 0; i < NT; i++) weights[i] = DW'(32767);
    bias = AW'(-5);
    run_frame(1'b0, -1, -1);
    drain();
    check("neg_first", first_data, -819180);
    check_frame("neg", 784, 1);

    // Reset at pixel (10,10) with cw_en high, then a fresh frame.
    pix_mode = 1;
    for (int i = 0; i < NT; i++) weights[i] = '0;
    weights[12] = DW'(1);
    bias = '0;
    run_frame(1'b0, 10, 10);
    drive(10, 10, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_frame("pre_reset", 172, 0);
    run_frame(1'b0, -1, -1);
    drain();
    check("after_reset_first", first_data, 66);
    check_frame("after_reset", 784, 1);

    // Restart at pixel (20,3) of frame 1; frame 1 emits 448 results and no frame_done.
    run_frame(1'b0, 20, 3);
    run_frame(1'b0, -1, -1);
    drain();
    check_frame("restart", 448 + 784, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
